conv_mac_rr_sched: RTL
======================

// Module: conv_mac_rr_sched
// PURPOSE
//  Round-robin scheduler that shares one saturating MAC between N convolution requesters.
//  Each requester streams operand pairs (x, f) as one dot-product burst, terminated by a last flag.
//  The scheduler grants one requester for a whole burst, accumulates with saturation and applies ReLU.
//  It returns the result to that requester only, then re-arbitrates.
//  Sits between N conv layer front-ends (X memory + filter ROM) and the single shared MAC datapath.
// PARAMETERS
//  N   2   number of requesters (>=1); NB = max(1,$clog2(N)) grant index width
//  T   11  signed data width of x, f, accumulator and result
// PORTS
//  clk        in   1     clock
//  reset      in   1     asynchronous active-high reset
//  x_data     in   N*T   requester i operand x at bits [i*T +: T], signed
//  f_data     in   N*T   requester i operand f at bits [i*T +: T], signed
//  req_valid  in   N     requester i has a beat on x_data/f_data
//  req_last   in   N     beat is the final pair of requester i's burst
//  req_ready  out  N     beat accepted when req_valid[i] & req_ready[i]
//  y_data     out  T     shared result bus, ReLU of accumulator
//  y_valid    out  N     one-hot: result available for requester i
//  y_ready    in   N     requester i consumes result when y_valid[i] & y_ready[i]
//  grant_id   out  NB    index of current/last granted requester
//  busy       out  1     high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, any state incl. mid-burst): state=IDLE, req_ready=0, y_valid=0, y_data=0,
//   grant_id=0, busy=0, rr pointer=0, accumulator=0, pipeline reg=0; the partial burst is discarded.
//  FSM states and transitions:
//  - IDLE:   search req_valid from rr pointer upward, wrapping modulo N; first hit becomes the grant.
//            Register grant_id; go to STREAM next cycle. No hit: stay in IDLE.
//            req_ready is all 0 in IDLE; arbitration uses req_valid only.
//  - STREAM: req_ready = one-hot(grant_id); all other ready bits are 0.
//            Each accepted beat: p = sat_T(x*f), where x*f is the full 2T-bit product.
//            p is registered into the pipeline register 1 cycle later.
//            On the following cycle: acc <= sat_T(acc + preg), computed at T+1 bits.
//            Cycles with no accepted beat load 0 into the pipeline register (bubble, no effect).
//            Accepted beat with req_last=1: go to DRAIN.
//  - DRAIN:  1 cycle; the last product enters acc. Go to OUTPUT.
//  - OUTPUT: y_valid = one-hot(grant_id); y_data = (acc<0) ? 0 : acc, stable while waiting.
//            On y_ready[grant_id]: acc<=0, preg<=0, rr pointer<=(grant_id+1) mod N, go to IDLE.
//            y_ready bits of non-granted requesters are ignored.
//  Saturation: sat_T clamps to [-2^(T-1), 2^(T-1)-1]; for T=11 that is [-1024, 1023].
//   Saturation applies at both the product and the accumulate stage.
//  Latency:
//  - Request to first possible accept: 1 cycle (IDLE then STREAM).
//  - Last beat accepted in cycle t: y_valid asserted from cycle t+2.
//  - Minimum back-to-back burst spacing: 1 IDLE cycle after the handshake.
//  Boundaries:
//  - Single-beat burst (last on first beat) is legal.
//  - A requester deasserting req_valid mid-burst keeps the grant (lock until last).
//  - Simultaneous requests from all requesters are served in strict rotation.
//  - N=1: grant_id is always 0.
//  - req_last without req_valid has no effect.
// TESTING
//  1. N=2, only req 0 sends x=(3,-2,5), f=(4,7,1), last on 3rd
//     -> y_valid=2'b01, y_data=3, 2 cycles after last accept.
//  2. Req 0 and req 1 valid together from reset, 1-beat bursts x=2,f=3 / x=-4,f=5
//     -> grants in order 0 then 1 then 0; results 6 then 0 (ReLU of -20).
//  3. Burst x=(100,100), f=(20,20) -> product clamps to 1023, sum clamps -> y_data=1023;
//     x=(-100),f=(20) -> y_data=0.
//  4. Req 1 granted, req 1 drops valid for 3 cycles mid-burst while req 0 is valid
//     -> req_ready[0] stays 0; result equals the gap-free burst.
//  5. Hold y_ready=0 for 5 cycles in OUTPUT -> y_valid and y_data stable; next grant only after handshake.
//  6. Assert reset in STREAM after 2 beats, then replay the burst
//     -> all outputs 0 immediately; replayed result has no residue from the aborted burst.

Source files
------------

// File: rtl/conv_mac_rr_sched.sv
// Round-robin scheduler that shares one saturating MAC between N requesters.
// A requester holds the grant for a whole burst; the ReLU result is returned to that requester only.
module conv_mac_rr_sched #(
  parameter int N  = 2,
  parameter int T  = 11,
  localparam int NB = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N*T-1:0]  x_data,
  input  logic [N*T-1:0]  f_data,
  input  logic [N-1:0]    req_valid,
  input  logic [N-1:0]    req_last,
  output logic [N-1:0]    req_ready,
  output logic [T-1:0]    y_data,
  output logic [N-1:0]    y_valid,
  input  logic [N-1:0]    y_ready,
  output logic [NB-1:0]   grant_id,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, OUTPUT} state_t;

  localparam logic signed [T-1:0]   SMAX = {1'b0, {(T-1){1'b1}}};
  localparam logic signed [T-1:0]   SMIN = {1'b1, {(T-1){1'b0}}};
  localparam logic signed [2*T-1:0] PMAX = {{(T+1){1'b0}}, {(T-1){1'b1}}};
  localparam logic signed [2*T-1:0] PMIN = {{(T+1){1'b1}}, {(T-1){1'b0}}};
  localparam logic signed [T:0]     AMAX = {2'b00, {(T-1){1'b1}}};
  localparam logic signed [T:0]     AMIN = {2'b11, {(T-1){1'b0}}};

  state_t                state;
  logic [NB-1:0]         rr;
  logic signed [T-1:0]   acc, preg;
  logic                  hit;
  logic [NB-1:0]         hit_idx, rr_nxt;
  logic [N-1:0]          hit_oh, gnt_oh;
  logic signed [T-1:0]   xs, fs, p_sat, acc_nxt;
  logic signed [2*T-1:0] prod;
  logic signed [T:0]     sum;
  logic                  beat_acc, out_ack;

  // First valid requester at or after the rr pointer, wrapping modulo N.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    for (int k = 0; k < N; k++) begin
      if (!hit && req_valid[(int'(rr) + k) % N]) begin
        hit     = 1'b1;
        hit_idx = NB'((int'(rr) + k) % N);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N; i++) begin
      hit_oh[i] = (NB'(i) == hit_idx);
      gnt_oh[i] = (NB'(i) == grant_id);
    end
  end

  assign xs   = x_data[int'(grant_id)*T +: T];
  assign fs   = f_data[int'(grant_id)*T +: T];
  assign prod = $signed({{T{xs[T-1]}}, xs}) * $signed({{T{fs[T-1]}}, fs});
  assign sum  = $signed({acc[T-1], acc}) + $signed({preg[T-1], preg});

  always_comb begin
    if (prod > PMAX)      p_sat = SMAX;
    else if (prod < PMIN) p_sat = SMIN;
    else                  p_sat = prod[T-1:0];
    if (sum > AMAX)       acc_nxt = SMAX;
    else if (sum < AMIN)  acc_nxt = SMIN;
    else                  acc_nxt = sum[T-1:0];
  end

  assign beat_acc = (state == STREAM) && req_valid[grant_id] && req_ready[grant_id];
  assign out_ack  = (state == OUTPUT) && y_ready[grant_id];
  assign rr_nxt   = (grant_id == NB'(N-1)) ? '0 : grant_id + 1'b1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= '0;
      acc       <= '0;
      preg      <= '0;
      req_ready <= '0;
      y_valid   <= '0;
      y_data    <= '0;
      grant_id  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (hit) begin
          grant_id  <= hit_idx;
          req_ready <= hit_oh;
          busy      <= 1'b1;
          state     <= STREAM;
        end
        STREAM: begin
          // Bubbles load zero into preg, so the accumulate stage runs every cycle.
          acc  <= acc_nxt;
          preg <= beat_acc ? p_sat : '0;
          if (beat_acc && req_last[grant_id]) begin
            req_ready <= '0;
            state     <= DRAIN;
          end
        end
        DRAIN: begin
          acc     <= acc_nxt;
          preg    <= '0;
          y_data  <= acc_nxt[T-1] ? '0 : acc_nxt;
          y_valid <= gnt_oh;
          state   <= OUTPUT;
        end
        OUTPUT: if (out_ack) begin
          y_valid <= '0;
          acc     <= '0;
          preg    <= '0;
          rr      <= rr_nxt;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
